bnn_xnor_layer2: RTL and testbench

BNN_XNOR_LAYER2 -- requirements
Module: bnn_xnor_layer2

---
 rtl/bnn_xnor_layer2.sv | 190 +++++++++++++++++++
 tb/tb_bnn_xnor_layer2.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_xnor_layer2.sv
`default_nettype none
// ============================================================================
// Module      : bnn_xnor_layer2
// Description : Binarized fully-connected layer with XNOR-popcount neurons.
//               A captured activation vector is scored against each weight
//               row one CHUNK-bit slice per cycle. Each neuron output is
//               thresholded, and a running argmax tracks the best neuron.
//               Results are held until the consumer accepts them.
// Ports       : clk, reset            - clock, async active-high reset
//               in_valid/in_ready/in_bits - activation vector handshake
//               wt_we/wt_addr/wt_data - weight row write (IDLE only)
//               busy                  - high whenever not IDLE
//               out_valid/out_ready   - result handshake
//               out_bits/out_score/out_class - thresholded outputs,
//                                       winning popcount, winning index
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_xnor_layer2 #(
   parameter int N_IN   = 128,
   parameter int N_OUT  = 16,
   parameter int CHUNK  = 32,
   parameter int THRESH = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N_IN-1:0]           in_bits,
   input  logic                      wt_we,
   input  logic [$clog2(N_OUT)-1:0]  wt_addr,
   input  logic [N_IN-1:0]           wt_data,
   output logic                      busy,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N_OUT-1:0]          out_bits,
   output logic [$clog2(N_IN+1)-1:0] out_score,
   output logic [$clog2(N_OUT)-1:0]  out_class
);

   localparam int c_N_CHUNK = N_IN / CHUNK;
   localparam int c_CW      = (c_N_CHUNK > 1) ? $clog2(c_N_CHUNK) : 1;
   localparam int c_DW      = $clog2(N_OUT);
   localparam int c_SW      = $clog2(N_IN + 1);
   localparam int c_PW      = $clog2(CHUNK + 1);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_COMPUTE = 2'd1;
   localparam logic [1:0] c_HOLD    = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic [N_IN-1:0]  r_wt [0:N_OUT-1];
   logic [N_IN-1:0]  r_in_bits;
   logic [c_CW-1:0]  r_c;
   logic [c_DW-1:0]  r_d;
   logic [c_SW-1:0]  r_acc;

   logic [N_IN-1:0]  w_row;
   logic [CHUNK-1:0] w_in_chunk [0:c_N_CHUNK-1];
   logic [CHUNK-1:0] w_wt_chunk [0:c_N_CHUNK-1];
   logic [CHUNK-1:0] w_xnor;
   logic [c_PW-1:0]  w_pop;
   logic [c_SW-1:0]  w_final;
   logic             w_accept;
   logic             w_last_chunk;
   logic             w_last_neuron;

   // ---------------------------------------------------------------------
   // Chunk slicing of the captured vector and the current neuron's row
   // ---------------------------------------------------------------------
   assign w_row = r_wt[r_d];

   generate
      for (genvar g = 0; g < c_N_CHUNK; g++) begin : g_chunk
         assign w_in_chunk[g] = r_in_bits[g*CHUNK +: CHUNK];
         assign w_wt_chunk[g] = w_row[g*CHUNK +: CHUNK];
      end
   endgenerate

   // XNOR + popcount of one slice; w_final is the accumulated count
   // including this slice, which at the last slice is the neuron's total.
   always_comb begin
      w_xnor = ~(w_in_chunk[r_c] ^ w_wt_chunk[r_c]);
      w_pop  = '0;
      for (int j = 0; j < CHUNK; j++) begin
         w_pop = w_pop + c_PW'(w_xnor[j]);
      end
      w_final = r_acc + c_SW'(w_pop);
   end

   assign w_accept      = in_valid && (r_state == c_IDLE);
   assign w_last_chunk  = (r_c == c_CW'(c_N_CHUNK - 1));
   assign w_last_neuron = (r_d == c_DW'(N_OUT - 1));

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM: next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (in_valid) begin
               w_state_next = c_COMPUTE;
            end
         end
         c_COMPUTE: begin
            if (w_last_chunk && w_last_neuron) begin
               w_state_next = c_HOLD;
            end
         end
         c_HOLD: begin
            if (out_ready) begin
               w_state_next = c_IDLE;
            end
         end
         default: w_state_next = c_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready  = (r_state == c_IDLE);
      busy      = (r_state != c_IDLE);
      out_valid = (r_state == c_HOLD);
   end

   // ---------------------------------------------------------------------
   // Weight store: writable only while IDLE. A write coinciding with an
   // accept commits on the same edge, so the computation that starts on
   // the next cycle already sees the new row.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < N_OUT; n++) begin
            r_wt[n] <= '0;
         end
      end else if (wt_we && (r_state == c_IDLE)) begin
         r_wt[wt_addr] <= wt_data;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath: counters, accumulator, thresholded outputs, running argmax.
   // Result registers are only touched during COMPUTE, so they hold their
   // last values through HOLD and the following IDLE.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_bits <= '0;
         r_c       <= '0;
         r_d       <= '0;
         r_acc     <= '0;
         out_bits  <= '0;
         out_score <= '0;
         out_class <= '0;
      end else if (w_accept) begin
         r_in_bits <= in_bits;
         r_c       <= '0;
         r_d       <= '0;
         r_acc     <= '0;
      end else if (r_state == c_COMPUTE) begin
         if (w_last_chunk) begin
            r_acc         <= '0;
            r_c           <= '0;
            r_d           <= r_d + 1'b1;
            out_bits[r_d] <= (w_final >= c_SW'(THRESH));
            // Neuron 0 seeds the running best; strict '>' keeps the
            // lowest index on ties.
            if ((r_d == '0) || (w_final > out_score)) begin
               out_score <= w_final;
               out_class <= r_d;
            end
         end else begin
            r_acc <= w_final;
            r_c   <= r_c + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bnn_xnor_layer2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bnn_xnor_layer2
// Description : Self-checking bench for bnn_xnor_layer2. Expected results
//               come from a bench-side weight model and are queued when a
//               vector is accepted, then popped when out_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_xnor_layer2;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic         in_valid  = 1'b0;
   logic         wt_we     = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_bits   = '0;
   logic [127:0] wt_data   = '0;
   logic [3:0]   wt_addr   = '0;
   logic         in_ready;
   logic         busy;
   logic         out_valid;
   logic [15:0]  out_bits;
   logic [7:0]   out_score;
   logic [3:0]   out_class;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [15:0] bits;
      logic [7:0]  score;
      logic [3:0]  cls;
   } exp_t;

   exp_t         sb[$];
   logic [127:0] m_wt [0:15];

   always #5 clk = ~clk;

   bnn_xnor_layer2 #(
      .N_IN   (128),
      .N_OUT  (16),
      .CHUNK  (32),
      .THRESH (64)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bits   (in_bits),
      .wt_we     (wt_we),
      .wt_addr   (wt_addr),
      .wt_data   (wt_data),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (out_bits),
      .out_score (out_score),
      .out_class (out_class)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reference: full-width XNOR popcount per neuron, threshold, argmax
   function automatic exp_t model(input logic [127:0] v);
      exp_t e;
      int   pc;
      e = '0;
      for (int n = 0; n < 16; n++) begin
         pc = $countones(~(v ^ m_wt[n]));
         e.bits[n] = (pc >= 64);
         if ((n == 0) || (pc > int'(e.score))) begin
            e.score = 8'(pc);
            e.cls   = 4'(n);
         end
      end
      return e;
   endfunction

   task automatic write_row(input int a, input logic [127:0] d);
      @(negedge clk);
      wt_we   = 1'b1;
      wt_addr = 4'(a);
      wt_data = d;
      m_wt[a] = d;
      @(negedge clk);
      wt_we = 1'b0;
   endtask

   task automatic accept(input logic [127:0] v, input bit we, input int a, input logic [127:0] d);
      @(negedge clk);
      check_eq("in_ready_idle", in_ready, 1'b1);
      in_valid = 1'b1;
      in_bits  = v;
      wt_we    = we;
      wt_addr  = 4'(a);
      wt_data  = d;
      if (we) m_wt[a] = d;
      sb.push_back(model(v));
      @(negedge clk);
      in_valid = 1'b0;
      wt_we    = 1'b0;
      check_eq("busy_compute", busy, 1'b1);
      check_eq("in_ready_compute", in_ready, 1'b0);
   endtask

   // Called at the first falling edge after the accept edge T; each further
   // falling edge marks one more COMPUTE edge, so out_valid must show at 64.
   task automatic wait_result(output exp_t e);
      int cnt = 0;
      while (!out_valid && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      check_eq("latency", cnt, 64);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      check_eq("out_bits", out_bits, e.bits);
      check_eq("out_score", out_score, e.score);
      check_eq("out_class", out_class, e.cls);
   endtask

   task automatic release_out(input exp_t e);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq("out_valid_drop", out_valid, 1'b0);
      check_eq("in_ready_after", in_ready, 1'b1);
      @(negedge clk);
      check_eq("retain_bits", out_bits, e.bits);
      check_eq("retain_score", out_score, e.score);
      check_eq("retain_class", out_class, e.cls);
   endtask

   task automatic run(input logic [127:0] v);
      exp_t e;
      accept(v, 1'b0, 0, '0);
      wait_result(e);
      release_out(e);
   endtask

   initial begin
      logic [127:0] v;
      logic [127:0] v2;
      exp_t         e;
      int           seen;

      for (int n = 0; n < 16; n++) m_wt[n] = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_out_bits", out_bits, 16'h0);
      check_eq("rst_out_score", out_score, 8'h0);
      check_eq("rst_out_class", out_class, 4'h0);

      // All rows +1, all inputs +1
      for (int n = 0; n < 16; n++) write_row(n, '1);
      run('1);
      // All rows +1, all inputs -1
      run('0);

      // Only row 9 matches
      v = rnd128();
      for (int n = 0; n < 16; n++) write_row(n, (n == 9) ? v : ~v);
      run(v);

      // Rows 3,5 match fully, row 7 matches low half (popcount 64)
      v = rnd128();
      for (int n = 0; n < 16; n++) begin
         if (n == 3 || n == 5) write_row(n, v);
         else if (n == 7)      write_row(n, {~v[127:64], v[63:0]});
         else                  write_row(n, ~v);
      end
      run(v);

      // Write coinciding with accept: computation uses the new row 12
      v2 = rnd128();
      accept(v2, 1'b1, 12, v2);
      wait_result(e);
      release_out(e);

      // Random weights and vectors
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 16; n++) write_row(n, rnd128());
         run(rnd128());
      end

      // HOLD stability: in_valid and wt_we are ignored while held
      v = rnd128();
      accept(v, 1'b0, 0, '0);
      wait_result(e);
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_bits  = rnd128();
         wt_we    = 1'b1;
         wt_addr  = 4'(k);
         wt_data  = rnd128();
         @(negedge clk);
         check_eq("hold_valid", out_valid, 1'b1);
         check_eq("hold_in_ready", in_ready, 1'b0);
         check_eq("hold_bits", out_bits, e.bits);
         check_eq("hold_score", out_score, e.score);
         check_eq("hold_class", out_class, e.cls);
      end
      in_valid = 1'b0;
      wt_we    = 1'b0;
      release_out(e);
      // Weights untouched: a rerun must still match the unchanged model
      run(v);

      // Reset during the 30th COMPUTE cycle aborts the run
      accept('1, 1'b0, 0, '0);
      repeat (29) @(negedge clk);
      reset = 1'b1;
      if (sb.size() > 0) void'(sb.pop_back());
      for (int n = 0; n < 16; n++) m_wt[n] = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_eq("abort_no_valid", seen, 0);
      check_eq("abort_in_ready", in_ready, 1'b1);
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_out_bits", out_bits, 16'h0);
      run('1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
